// File: rtl/issue_ibuffer_if.sv
// issue_ibuffer_if: decode-to-buffer and buffer-to-scoreboard signal bundle.
//   dec_valid/dec_wid/dec_data/dec_ready : one decoded instruction per cycle,
//                                          tagged with a slice-local warp index
//   out_valid/out_data/out_ready         : per-warp head-of-FIFO streams
//   ibuf_pop                             : per-warp dequeue pulse for credit return
// master = decode + scoreboard side, slave = the instruction buffer.
interface issue_ibuffer_if #(
  parameter int NUM_WARPS = 4,
  parameter int DATAW     = 128,
  parameter int WID_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
);
  logic                            dec_valid;
  logic [WID_W-1:0]                dec_wid;
  logic [DATAW-1:0]                dec_data;
  logic                            dec_ready;
  logic [NUM_WARPS-1:0]            out_valid;
  logic [NUM_WARPS-1:0][DATAW-1:0] out_data;
  logic [NUM_WARPS-1:0]            out_ready;
  logic [NUM_WARPS-1:0]            ibuf_pop;

  modport master (
    output dec_valid, dec_wid, dec_data, out_ready,
    input  dec_ready, out_valid, out_data, ibuf_pop
  );

  modport slave (
    input  dec_valid, dec_wid, dec_data, out_ready,
    output dec_ready, out_valid, out_data, ibuf_pop
  );
endinterface

// File: rtl/issue_ibuffer.sv
// issue_ibuffer: per-warp instruction buffer for one issue slice.
// Decoded instructions are steered by dec_wid into one FIFO per warp; each
// warp's oldest entry is offered as an independent valid/ready stream.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   bus (slave)       : decode input, per-warp head outputs, ibuf_pop pulses
//   perf_full_stalls  : cycles where decode was held off by a full warp FIFO

// One warp's FIFO. Push/pop legality is enforced by the parent: no push while
// full, no pop while empty.
module ibuf_warp_fifo #(
  parameter int DEPTH = 4,
  parameter int DATAW = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DATAW-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [DATAW-1:0] head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][DATAW-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic [CNT_W-1:0]            count;

  // Payload storage carries no reset; entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap modulo DEPTH by overflow (DEPTH is a power of two).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
endmodule

module issue_ibuffer #(
  parameter int NUM_WARPS = 4,
  parameter int DEPTH     = 4,
  parameter int DATAW     = 128,
  parameter int CTR_W     = 44
) (
  input  logic             clk,
  input  logic             reset,
  issue_ibuffer_if.slave   bus,
  output logic [CTR_W-1:0] perf_full_stalls
);
  localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  logic [NUM_WARPS-1:0]            full, empty, push, pop;
  logic [NUM_WARPS-1:0][DATAW-1:0] head;
  logic                            full_sel;

  // Full flag of the addressed warp. An out-of-range wid selects nothing;
  // that case is illegal and caught by the assertion below.
  always_comb begin
    full_sel = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++)
      if (bus.dec_wid == WID_W'(w)) full_sel = full[w];
  end

  // Depends only on registered count and dec_wid: never on out_ready, so no
  // combinational path from consumer back to decode. A full warp stays
  // closed even if it pops this cycle.
  assign bus.dec_ready = ~reset & ~full_sel;

  // Heads are masked during reset so entries about to be discarded are
  // never handed out or credited back via ibuf_pop.
  assign bus.out_valid = ~empty & {NUM_WARPS{~reset}};
  assign pop           = bus.out_valid & bus.out_ready;
  assign bus.ibuf_pop  = pop;
  assign bus.out_data  = head;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    assign push[w] = bus.dec_valid & bus.dec_ready & (bus.dec_wid == WID_W'(w));

    ibuf_warp_fifo #(
      .DEPTH (DEPTH),
      .DATAW (DATAW)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[w]),
      .push_data (bus.dec_data),
      .pop       (pop[w]),
      .full      (full[w]),
      .empty     (empty[w]),
      .head      (head[w])
    );
  end

  // Counts every cycle decode is held off; wraps at 2^CTR_W.
  always_ff @(posedge clk) begin
    if (reset)                        perf_full_stalls <= '0;
    else if (bus.dec_valid && full_sel) perf_full_stalls <= perf_full_stalls + CTR_W'(1);
  end

  wid_legal: assert property (@(posedge clk) disable iff (reset)
    bus.dec_valid |-> ({1'b0, bus.dec_wid} < (WID_W + 1)'(NUM_WARPS)));
endmodule

// File: tb/tb_issue_ibuffer.sv
// tb_issue_ibuffer: self-checking bench for issue_ibuffer.
// A per-warp queue scoreboard is fed on every accepted push and drained on
// every pop; DUT outputs are compared against it each cycle at the falling
// edge. A vector table adds explicit expectations for handshake/stall cases.
module tb_issue_ibuffer;
  localparam int NW = 4;
  localparam int D  = 4;
  localparam int DW = 128;
  localparam int CW = 44;
  localparam int WW = 2;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] perf;

  issue_ibuffer_if #(.NUM_WARPS(NW), .DATAW(DW)) bus ();

  issue_ibuffer #(
    .NUM_WARPS (NW),
    .DEPTH     (D),
    .DATAW     (DW),
    .CTR_W     (CW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus),
    .perf_full_stalls (perf)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] sq[NW][$];
  logic [CW-1:0] perf_m = '0;
  int            nvec = 0;
  int            nerr = 0;
  logic          last_acc = 1'b0;
  int            rx3 = 0;

  typedef struct {
    logic          v;
    logic [WW-1:0] wid;
    logic [DW-1:0] data;
    logic [NW-1:0] rdy;
    logic          e_ready;
    logic [NW-1:0] e_valid;
    logic [NW-1:0] e_pop;
    logic [CW-1:0] e_perf;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [WW-1:0] wid, input logic [DW-1:0] d,
                       input logic [NW-1:0] r);
    bus.dec_valid = v;
    bus.dec_wid   = wid;
    bus.dec_data  = d;
    bus.out_ready = r;
  endtask

  // Compare current combinational outputs against the scoreboard.
  task automatic sample();
    logic [NW-1:0] ev, ep;
    @(negedge clk);
    ev = '0;
    ep = '0;
    if (!reset)
      for (int w = 0; w < NW; w++) begin
        ev[w] = (sq[w].size() > 0);
        ep[w] = ev[w] & bus.out_ready[w];
      end
    check("dec_ready", DW'(bus.dec_ready), DW'(!reset && (sq[bus.dec_wid].size() < D)));
    check("out_valid", DW'(bus.out_valid), DW'(ev));
    check("ibuf_pop",  DW'(bus.ibuf_pop),  DW'(ep));
    if (!reset) check("perf_full_stalls", DW'(perf), DW'(perf_m));
    for (int w = 0; w < NW; w++)
      if (ev[w]) check($sformatf("out_data[%0d]", w), bus.out_data[w], sq[w][0]);
  endtask

  // Clock edge: update the scoreboard from the inputs that were applied.
  task automatic advance();
    int   pre[NW];
    logic acc;
    @(posedge clk);
    if (reset) begin
      for (int w = 0; w < NW; w++) sq[w].delete();
      perf_m   = '0;
      last_acc = 1'b0;
    end else begin
      for (int w = 0; w < NW; w++) pre[w] = sq[w].size();
      acc = bus.dec_valid && (pre[bus.dec_wid] < D);
      if (bus.dec_valid && !acc) perf_m = perf_m + CW'(1);
      for (int w = 0; w < NW; w++)
        if (pre[w] > 0 && bus.out_ready[w]) begin
          if (w == 3) rx3++;
          void'(sq[w].pop_front());
        end
      if (acc) sq[bus.dec_wid].push_back(bus.dec_data);
      last_acc = acc;
    end
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int sent;
    int busy;

    //             v     wid   data        rdy      rdy_e valid    pop      perf
    tbl[0]  = '{1'b1, 2'd2, 128'hA5, 4'b0000, 1'b1, 4'b0000, 4'b0000, 44'd0};
    tbl[1]  = '{1'b0, 2'd2, 128'h0,  4'b0100, 1'b1, 4'b0100, 4'b0100, 44'd0};
    tbl[2]  = '{1'b0, 2'd0, 128'h0,  4'b0000, 1'b1, 4'b0000, 4'b0000, 44'd0};
    tbl[3]  = '{1'b1, 2'd0, 128'h1,  4'b0000, 1'b1, 4'b0000, 4'b0000, 44'd0};
    tbl[4]  = '{1'b1, 2'd0, 128'h2,  4'b0000, 1'b1, 4'b0001, 4'b0000, 44'd0};
    tbl[5]  = '{1'b1, 2'd0, 128'h3,  4'b0000, 1'b1, 4'b0001, 4'b0000, 44'd0};
    tbl[6]  = '{1'b1, 2'd0, 128'h4,  4'b0000, 1'b1, 4'b0001, 4'b0000, 44'd0};
    tbl[7]  = '{1'b1, 2'd0, 128'h5,  4'b0000, 1'b0, 4'b0001, 4'b0000, 44'd0};
    tbl[8]  = '{1'b1, 2'd0, 128'h5,  4'b0000, 1'b0, 4'b0001, 4'b0000, 44'd1};
    tbl[9]  = '{1'b1, 2'd0, 128'h5,  4'b0000, 1'b0, 4'b0001, 4'b0000, 44'd2};
    tbl[10] = '{1'b1, 2'd1, 128'h6,  4'b0000, 1'b1, 4'b0001, 4'b0000, 44'd3};
    tbl[11] = '{1'b1, 2'd0, 128'h7,  4'b0001, 1'b0, 4'b0011, 4'b0001, 44'd3};
    tbl[12] = '{1'b1, 2'd0, 128'h7,  4'b0000, 1'b1, 4'b0011, 4'b0000, 44'd4};
    tbl[13] = '{1'b0, 2'd0, 128'h0,  4'b0000, 1'b0, 4'b0011, 4'b0000, 44'd4};

    // Reset state
    drive(1'b0, '0, '0, '0);
    reset = 1'b1;
    advance();
    drive(1'b1, 2'd0, '0, 4'b1111);
    cyc();
    reset = 1'b0;

    // Single push, fill to full, stall counting, full-with-pop
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].wid, tbl[i].data, tbl[i].rdy);
      sample();
      check($sformatf("tbl%0d dec_ready", i), DW'(bus.dec_ready), DW'(tbl[i].e_ready));
      check($sformatf("tbl%0d out_valid", i), DW'(bus.out_valid), DW'(tbl[i].e_valid));
      check($sformatf("tbl%0d ibuf_pop", i),  DW'(bus.ibuf_pop),  DW'(tbl[i].e_pop));
      check($sformatf("tbl%0d perf", i),      DW'(perf),          DW'(tbl[i].e_perf));
      advance();
    end

    // Drain everything
    drive(1'b0, '0, '0, 4'b1111);
    busy = 1;
    for (int i = 0; i < 12 && busy != 0; i++) begin
      cyc();
      busy = 0;
      for (int w = 0; w < NW; w++) busy += sq[w].size();
    end
    sample();
    check("drain_empty", DW'(bus.out_valid), DW'(4'b0000));
    advance();

    // Wrap-around through warp 3 with a toggling consumer
    sent = 0;
    rx3  = 0;
    for (int i = 0; i < 60 && rx3 < 10; i++) begin
      drive(sent < 10, 2'd3, DW'(sent), {i[0], 3'b000});
      cyc();
      if (last_acc) sent++;
    end
    check("wrap_sent", DW'(sent), DW'(10));
    check("wrap_rx",   DW'(rx3),  DW'(10));

    // Multi-warp pop
    for (int w = 0; w < NW; w++) begin
      drive(1'b1, WW'(w), {$urandom, $urandom, $urandom, $urandom}, 4'b0000);
      cyc();
    end
    drive(1'b0, '0, '0, 4'b1111);
    sample();
    check("multi_pop", DW'(bus.ibuf_pop), DW'(4'b1111));
    advance();
    drive(1'b0, '0, '0, 4'b0000);
    sample();
    check("multi_after", DW'(bus.out_valid), DW'(4'b0000));
    advance();

    // Reset mid-operation
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, WW'(i / 2), {$urandom, $urandom, $urandom, $urandom}, 4'b0000);
      cyc();
    end
    reset = 1'b1;
    drive(1'b1, 2'd0, 128'h55, 4'b1111);
    sample();
    check("rst_mid_pop",   DW'(bus.ibuf_pop),  DW'(4'b0000));
    check("rst_mid_valid", DW'(bus.out_valid), DW'(4'b0000));
    advance();
    reset = 1'b0;
    drive(1'b1, 2'd0, 128'h77, 4'b0000);
    sample();
    check("post_rst_ready", DW'(bus.dec_ready), DW'(1'b1));
    check("post_rst_valid", DW'(bus.out_valid), DW'(4'b0000));
    check("post_rst_perf",  DW'(perf),          DW'(0));
    advance();
    drive(1'b0, 2'd0, '0, 4'b0000);
    sample();
    check("post_rst_head_v", DW'(bus.out_valid), DW'(4'b0001));
    check("post_rst_head_d", bus.out_data[0],    128'h77);
    advance();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/issue_ibuffer.md
# issue_ibuffer

Per-warp instruction buffer for one issue slice. It sits between the decode stage and the scoreboard. It accepts one decoded instruction per cycle tagged with a slice-local warp index and holds it in that warp's FIFO. It presents each warp's oldest instruction as an independent valid/ready stream to the scoreboard, and it returns a one-cycle pop pulse per warp to the warp scheduler for issue-credit accounting.

## Interface
Parameters:
- NUM_WARPS, 4 — warps per issue slice (PER_ISSUE_WARPS); ≥1.
- DEPTH, 4 — entries per warp FIFO; power of two, ≥2.
- DATAW, 128 — decoded instruction payload width (uuid, tmask, PC, ex_type, op_type, op_args, wb, rd, rs1–rs3).
- CTR_W, 44 — stall counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset: synchronous, active-high. Clock is clk.
- dec_valid  in  1  decode instruction valid.
- dec_wid  in  clog2(NUM_WARPS) (min 1)  target warp of the decode instruction.
- dec_data  in  DATAW  decoded payload.
- dec_ready  out  1  buffer accepts the decode instruction this cycle.
- out_valid  out  NUM_WARPS  per-warp head entry valid.
- out_data  out  NUM_WARPS×DATAW  per-warp head payload.
- out_ready  in  NUM_WARPS  per-warp consumer (scoreboard staging) ready.
- ibuf_pop  out  NUM_WARPS  per-warp dequeue pulse.
- perf_full_stalls  out  CTR_W  count of cycles where decode was held off by a full FIFO.

## Operation
- Per-warp state:
  - storage[DEPTH] of DATAW bits.
  - wr_ptr and rd_ptr, clog2(DEPTH) bits each; they wrap modulo DEPTH naturally.
  - count, clog2(DEPTH+1) bits.
- Flags: full[w] = (count[w]==DEPTH); empty[w] = (count[w]==0).
- dec_ready = ~reset && ~full[dec_wid]. This is combinational from registered count and dec_wid only. There is no dependence on out_ready, so the path is not a combinational loop.
- push[w] = dec_valid && dec_ready && dec_wid==w. At most one warp pushes per cycle.
- pop[w] = out_valid[w] && out_ready[w]. Any subset of warps may pop in the same cycle.
- out_valid[w] = ~empty[w]. out_data[w] = storage[w][rd_ptr[w]].
- ibuf_pop[w] = pop[w], combinational.
- count[w] update:
  - +1 on push only.
  - −1 on pop only.
  - unchanged on simultaneous push and pop.
- A push to a full warp FIFO is impossible (dec_ready low) even if that warp pops in the same cycle. There is no full-bypass.
- Push into an empty FIFO is not forwarded combinationally: no empty-bypass.
- perf_full_stalls increments by 1 each cycle with dec_valid && full[dec_wid]. It wraps at 2^CTR_W.
- A dec_wid ≥ NUM_WARPS while dec_valid is high is illegal. The simulation assertion must fire.

## Timing
- Reset (synchronous, held ≥1 cycle):
  - count, wr_ptr, rd_ptr and perf_full_stalls go to 0.
  - out_valid = 0 and ibuf_pop = 0.
  - dec_ready = 0 during reset and 1 in the first cycle after reset.
  - Storage is not reset, and out_data is don't-care while out_valid = 0.
- Reset mid-operation discards all buffered entries. No ibuf_pop is emitted for discarded entries.
- Latency: an instruction pushed in cycle N is visible at out_valid/out_data in cycle N+1 at the earliest.
- Throughput:
  - One push per cycle slice-wide.
  - One pop per cycle per warp.
  - A warp sustaining push+pop every cycle keeps count constant.
- Handshake rules:
  - out_data[w] must be stable while out_valid[w] && ~out_ready[w].
  - The consumer may raise out_ready independent of out_valid.
- Ordering: strict FIFO within each warp. There is no ordering guarantee across warps.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. Entries remain correct across the wrap.

## Test plan
- Reset then single push: after reset, dec_valid=1, dec_wid=2, dec_data=0xA5 in cycle 0. Required: out_valid=4'b0100 and out_data[2]=0xA5 in cycle 1. out_ready[2]=1 in cycle 1 gives ibuf_pop=4'b0100 in cycle 1 and out_valid=0 in cycle 2.
- Fill to full, DEPTH=4, warp 0, out_ready=0:
  - Pushes 1,2,3,4 are accepted and dec_ready drops for wid 0.
  - A 5th push is held, and perf_full_stalls increments by 1 per held cycle (3 held cycles gives 3).
  - dec_wid=1 is still accepted in the same state.
- Full with simultaneous pop, warp 0 full: out_ready[0]=1 with dec_valid to wid 0. Required: push rejected that cycle and count becomes 3; the next cycle's push is accepted.
- Wrap-around: stream 10 instructions (values 0..9) through warp 3 with out_ready[3] toggling every other cycle. Required: the output sequence is exactly 0..9, with no loss or duplication.
- Multi-warp pop: warps 0–3 each hold one entry and out_ready=4'b1111. Required: ibuf_pop=4'b1111 for one cycle, then out_valid=0.
- Reset mid-operation: warps 0 and 1 hold 2 entries each and reset is asserted for 1 cycle. Required: out_valid=0, no ibuf_pop, and a post-reset push to wid 0 appears as the head entry.
